serial_adder_acc: RTL and testbench



---
 rtl/serial_adder_acc_if.sv | 27 ++
 rtl/serial_adder_acc.sv | 120 ++++++++++++
 tb/tb_serial_adder_acc.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_acc_if.sv
// Handshake and operand bundle for serial_adder_acc.
// The master side issues operations; the slave side is the adder core.
interface serial_adder_acc_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output ena, start, op, a, b, cin,
    input  sum, cout, overflow, busy, done
  );

  modport slave (
    input  ena, start, op, a, b, cin,
    output sum, cout, overflow, busy, done
  );
endinterface

// File: rtl/serial_adder_acc.sv
// Digit-serial adder / subtractor / accumulator.
// Processes DIGIT bits per enabled clock with a registered carry; a WIDTH-bit
// operation takes N = WIDTH/DIGIT enabled cycles. The partial result is shifted
// into the vacated top of the A operand register, so no separate result shift
// register is needed, and sum only updates on completion.
module serial_adder_acc #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_acc_if.slave  bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic       { IDLE, RUN } state_t;
  typedef enum logic [1:0] { OP_ADD = 2'b00, OP_SUB = 2'b01,
                             OP_ACC = 2'b10, OP_CLR = 2'b11 } op_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;       // operand A; upper digits fill with result
  logic [WIDTH-1:0] op_b;       // operand B (inverted for SUB)
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;      // original, unshifted sign bits for overflow
  logic             b_msb;

  op_t              op_sel;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic             load_c;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] a_next;

  // Operand selection at accept time and the per-cycle digit add.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op_sel = op_t'(bus.op);
    load_a = bus.a;
    load_b = bus.b;
    load_c = bus.cin;
    case (op_sel)
      OP_SUB: begin
        load_b = ~bus.b;
        load_c = 1'b1;
      end
      OP_ACC:  load_a = bus.sum;
      default: ;
    endcase
    slice = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
          + {{DIGIT{1'b0}}, carry};
  end

  // New result digit enters A from the MSB side as A shifts right.
  if (DIGIT < WIDTH) begin : g_shift
    assign a_next = {slice[DIGIT-1:0], op_a[WIDTH-1:DIGIT]};
  end else begin : g_single
    assign a_next = slice[DIGIT-1:0];
  end

  // Control FSM, datapath registers and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register is in the async reset, so an abort mid-run leaves no stale state.
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else if (bus.ena) begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (op_sel == OP_CLR) begin
              bus.sum      <= '0;
              bus.cout     <= 1'b0;
              bus.overflow <= 1'b0;
              bus.done     <= 1'b1;
            end else begin
              op_a     <= load_a;
              op_b     <= load_b;
              carry    <= load_c;
              a_msb    <= load_a[WIDTH-1];
              b_msb    <= load_b[WIDTH-1];
              cnt      <= '0;
              bus.busy <= 1'b1;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          op_a  <= a_next;
          op_b  <= op_b >> DIGIT;
          carry <= slice[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.sum      <= a_next;
            bus.cout     <= slice[DIGIT];
            bus.overflow <= (a_msb == b_msb) && (a_next[WIDTH-1] != a_msb);
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_acc.sv
// Directed bench for serial_adder_acc (WIDTH=8, DIGIT=2).
module tb_serial_adder_acc;
  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_adder_acc_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_acc #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse through the accept edge.
  task automatic start_op(input logic [1:0] o, input logic [7:0] av,
                          input logic [7:0] bv, input logic ci);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    tick();
    bus.start = 1'b0;
  endtask

  // Wait for done with a bounded budget; report latency, busy cycles and
  // whether sum moved before done.
  task automatic wait_done(output int cycles, output int busy_cycles, output logic moved);
    logic [7:0] prev;
    prev        = bus.sum;
    cycles      = 0;
    busy_cycles = 0;
    moved       = 1'b0;
    while (!bus.done && cycles < 20) begin
      if (bus.busy) busy_cycles++;
      if (bus.sum !== prev) moved = 1'b1;
      tick();
      cycles++;
    end
  endtask

  int   lat;
  int   bcy;
  logic moved;
  int   done_seen;
  int   busy_seen;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.ena   = 1'b1;
    bus.start = 1'b0;
    bus.op    = ADD;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    #12;
    check("rst_sum",  bus.sum, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_ovf",  bus.overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // ADD 0x3C + 0x55
    start_op(ADD, 8'h3C, 8'h55, 1'b0);
    check("add1_busy_after_accept", bus.busy, 1'b1);
    wait_done(lat, bcy, moved);
    check("add1_latency", lat, 4);
    check("add1_busy_cycles", bcy, 4);
    check("add1_no_partial_sum", moved, 1'b0);
    check("add1_sum",  bus.sum, 8'h91);
    check("add1_cout", bus.cout, 1'b0);
    check("add1_ovf",  bus.overflow, 1'b1);
    check("add1_busy_at_done", bus.busy, 1'b0);
    tick();
    check("add1_done_one_cycle", bus.done, 1'b0);

    // ADD 0xFF + 0x01 + cin
    start_op(ADD, 8'hFF, 8'h01, 1'b1);
    wait_done(lat, bcy, moved);
    check("add2_sum",  bus.sum, 8'h01);
    check("add2_cout", bus.cout, 1'b1);
    check("add2_ovf",  bus.overflow, 1'b0);
    check("add2_done", bus.done, 1'b1);

    // Back-to-back ACC started in the done cycle
    start_op(ACC, 8'h00, 8'h7F, 1'b0);
    check("acc_done_cleared", bus.done, 1'b0);
    check("acc_busy", bus.busy, 1'b1);
    wait_done(lat, bcy, moved);
    check("acc_latency", lat, 4);
    check("acc_sum",  bus.sum, 8'h80);
    check("acc_cout", bus.cout, 1'b0);
    check("acc_ovf",  bus.overflow, 1'b1);

    // CLR, also back-to-back
    start_op(CLR, 8'hAA, 8'hAA, 1'b1);
    check("clr_sum",  bus.sum, 8'h00);
    check("clr_cout", bus.cout, 1'b0);
    check("clr_ovf",  bus.overflow, 1'b0);
    check("clr_done", bus.done, 1'b1);
    check("clr_busy", bus.busy, 1'b0);
    tick();
    check("clr_done_drop", bus.done, 1'b0);
    check("clr_busy_after", bus.busy, 1'b0);

    // SUB 0x10 - 0x20
    start_op(SUB, 8'h10, 8'h20, 1'b1);
    wait_done(lat, bcy, moved);
    check("sub1_sum",  bus.sum, 8'hF0);
    check("sub1_cout", bus.cout, 1'b0);
    check("sub1_ovf",  bus.overflow, 1'b0);
    tick();

    // SUB 0x80 - 0x01
    start_op(SUB, 8'h80, 8'h01, 1'b0);
    wait_done(lat, bcy, moved);
    check("sub2_sum",  bus.sum, 8'h7F);
    check("sub2_cout", bus.cout, 1'b1);
    check("sub2_ovf",  bus.overflow, 1'b1);
    tick();

    // ADD 0x12 + 0x34 with a 3-cycle stall and start re-pulsed (as CLR) while busy
    start_op(ADD, 8'h12, 8'h34, 1'b0);
    lat = 0;
    while (!bus.done && lat < 20) begin
      bus.ena   = (lat >= 1 && lat <= 3) ? 1'b0 : 1'b1;
      bus.start = (lat == 2 || lat == 4) ? 1'b1 : 1'b0;
      bus.op    = CLR;
      tick();
      lat++;
    end
    bus.ena   = 1'b1;
    bus.start = 1'b0;
    check("stall_latency", lat, 7);
    check("stall_sum",  bus.sum, 8'h46);
    check("stall_cout", bus.cout, 1'b0);
    check("stall_ovf",  bus.overflow, 1'b0);
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
    end
    check("stall_no_second_done", done_seen, 0);
    check("stall_no_second_busy", busy_seen, 0);
    check("stall_sum_held", bus.sum, 8'h46);

    // Reset two cycles into an ADD
    start_op(ADD, 8'hAA, 8'h11, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_sum",  bus.sum, 8'h00);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_cout", bus.cout, 1'b0);
    check("abort_ovf",  bus.overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_no_busy", busy_seen, 0);

    start_op(ADD, 8'h01, 8'h01, 1'b0);
    wait_done(lat, bcy, moved);
    check("post_rst_latency", lat, 4);
    check("post_rst_sum", bus.sum, 8'h02);
    check("post_rst_cout", bus.cout, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
